// File: rtl/pit_table.sv
// Pending Interest Table: records interests, forwards new ones to fib,
// aggregates duplicates, matches returning data and relays its payload.
module pit_table #(
  parameter int unsigned ENTRIES       = 4,
  parameter int unsigned LIFETIME      = 1024,
  parameter int unsigned PAYLOAD_BYTES = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           interest_valid_i,
  input  logic [63:0]                    interest_prefix_i,
  input  logic [5:0]                     interest_len_i,
  output logic                           interest_ready_o,
  output logic                           interest_drop_o,
  output logic [63:0]                    pit_in_prefix_o,
  output logic [5:0]                     pit_in_len_o,
  output logic                           fib_out_bit_o,
  input  logic [63:0]                    pit_out_prefix_i,
  input  logic [5:0]                     pit_out_len_i,
  input  logic                           prefix_ready_i,
  output logic                           start_send_to_pit_o,
  output logic                           rejected_o,
  input  logic [7:0]                     out_data_i,
  output logic [7:0]                     data_out_o,
  output logic                           data_out_valid_o,
  output logic                           data_out_last_o,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy_o
);

  localparam int unsigned OccW  = $clog2(ENTRIES + 1);
  localparam int unsigned IdxW  = $clog2(ENTRIES);
  localparam int unsigned LifeW = $clog2(LIFETIME + 1);

  typedef enum logic [1:0] {StIdle, StFwd, StDataRx} state_e;

  state_e                 state_q, state_d;
  logic [ENTRIES-1:0]     valid_q, valid_d;
  logic [63:0]            prefix_q [ENTRIES];
  logic [5:0]             len_q    [ENTRIES];
  logic [LifeW-1:0]       life_q   [ENTRIES];
  logic [LifeW-1:0]       life_d   [ENTRIES];
  logic [63:0]            pit_in_prefix_q, pit_in_prefix_d;
  logic [5:0]             pit_in_len_q, pit_in_len_d;
  logic                   fib_out_q, fib_out_d;
  logic                   drop_q, drop_d;
  logic                   reject_q, reject_d;
  logic                   start_q, start_d;
  logic [7:0]             data_q, data_d;
  logic                   dvalid_q, dvalid_d;
  logic                   dlast_q, dlast_d;
  logic [7:0]             rx_cnt_q, rx_cnt_d;
  logic [OccW-1:0]        occ_q, occ_d;

  logic                   wr_en;
  logic [IdxW-1:0]        wr_idx;

  logic [63:0]            int_mask, dat_mask;
  logic [ENTRIES-1:0]     int_hit, dat_hit;
  logic                   int_any, dat_any, free_any;
  logic [IdxW-1:0]        int_idx, dat_idx, free_idx;

  assign interest_ready_o = (state_q == StIdle) && !prefix_ready_i && !rst_i;

  // Associative lookup for both key sources plus lowest-free-slot search.
  always_comb begin
    // Mask keeps the top len bits; len 0 yields an all-zero mask.
    int_mask = ~({64{1'b1}} >> interest_len_i);
    dat_mask = ~({64{1'b1}} >> pit_out_len_i);
    int_any  = 1'b0;
    dat_any  = 1'b0;
    free_any = 1'b0;
    int_idx  = '0;
    dat_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      int_hit[i] = valid_q[i] && (len_q[i] == interest_len_i) &&
                   (((prefix_q[i] ^ interest_prefix_i) & int_mask) == 64'd0);
      dat_hit[i] = valid_q[i] && (len_q[i] == pit_out_len_i) &&
                   (((prefix_q[i] ^ pit_out_prefix_i) & dat_mask) == 64'd0);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (int_hit[i]) begin
        int_any = 1'b1;
        int_idx = IdxW'(i);
      end
      if (dat_hit[i]) begin
        dat_any = 1'b1;
        dat_idx = IdxW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Next-state: FSM, entry aging, pulses and payload capture.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    pit_in_prefix_d = pit_in_prefix_q;
    pit_in_len_d    = pit_in_len_q;
    fib_out_d       = 1'b0;
    drop_d          = 1'b0;
    reject_d        = 1'b0;
    start_d         = 1'b0;
    data_d          = data_q;
    dvalid_d        = 1'b0;
    dlast_d         = 1'b0;
    rx_cnt_d        = rx_cnt_q;
    wr_en           = 1'b0;
    wr_idx          = free_idx;
    occ_d           = '0;

    // Aging first so that a same-cycle hit below overrides expiry.
    for (int i = 0; i < ENTRIES; i++) begin
      life_d[i] = life_q[i];
      if (valid_q[i]) begin
        life_d[i] = life_q[i] - LifeW'(1);
        if (life_q[i] == LifeW'(1)) valid_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (prefix_ready_i) begin
          if (dat_any) begin
            valid_d[dat_idx] = 1'b0;
            start_d          = 1'b1;
            rx_cnt_d         = 8'd0;
            state_d          = StDataRx;
          end else begin
            reject_d = 1'b1;
          end
        end else if (interest_valid_i) begin
          if (int_any) begin
            valid_d[int_idx] = 1'b1;
            life_d[int_idx]  = LifeW'(LIFETIME);
          end else if (free_any) begin
            wr_en            = 1'b1;
            valid_d[free_idx] = 1'b1;
            life_d[free_idx] = LifeW'(LIFETIME);
            pit_in_prefix_d  = interest_prefix_i;
            pit_in_len_d     = interest_len_i;
            state_d          = StFwd;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      StFwd: begin
        fib_out_d = 1'b1;
        reject_d  = prefix_ready_i;
        state_d   = StIdle;
      end
      StDataRx: begin
        reject_d = prefix_ready_i;
        // Count 0 is the start cycle; bytes arrive on counts 1..PAYLOAD_BYTES.
        if (rx_cnt_q != 8'd0) begin
          data_d   = out_data_i;
          dvalid_d = 1'b1;
          dlast_d  = (rx_cnt_q == 8'(PAYLOAD_BYTES));
        end
        if (rx_cnt_q == 8'(PAYLOAD_BYTES)) state_d = StIdle;
        rx_cnt_d = rx_cnt_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    for (int i = 0; i < ENTRIES; i++) begin
      occ_d = occ_d + OccW'(valid_d[i]);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      pit_in_prefix_q <= '0;
      pit_in_len_q    <= '0;
      fib_out_q       <= 1'b0;
      drop_q          <= 1'b0;
      reject_q        <= 1'b0;
      start_q         <= 1'b0;
      data_q          <= '0;
      dvalid_q        <= 1'b0;
      dlast_q         <= 1'b0;
      rx_cnt_q        <= '0;
      occ_q           <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      pit_in_prefix_q <= pit_in_prefix_d;
      pit_in_len_q    <= pit_in_len_d;
      fib_out_q       <= fib_out_d;
      drop_q          <= drop_d;
      reject_q        <= reject_d;
      start_q         <= start_d;
      data_q          <= data_d;
      dvalid_q        <= dvalid_d;
      dlast_q         <= dlast_d;
      rx_cnt_q        <= rx_cnt_d;
      occ_q           <= occ_d;
    end
  end

  // Entry storage: key written on allocation, lifetime every cycle.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst_i) begin
        prefix_q[i] <= '0;
        len_q[i]    <= '0;
        life_q[i]   <= '0;
      end else begin
        life_q[i] <= life_d[i];
        if (wr_en && (wr_idx == IdxW'(i))) begin
          prefix_q[i] <= interest_prefix_i;
          len_q[i]    <= interest_len_i;
        end
      end
    end
  end

  assign interest_drop_o     = drop_q;
  assign pit_in_prefix_o     = pit_in_prefix_q;
  assign pit_in_len_o        = pit_in_len_q;
  assign fib_out_bit_o       = fib_out_q;
  assign start_send_to_pit_o = start_q;
  assign rejected_o          = reject_q;
  assign data_out_o          = data_q;
  assign data_out_valid_o    = dvalid_q;
  assign data_out_last_o     = dlast_q;
  assign occupancy_o         = occ_q;

endmodule

// File: tb/tb_pit_table.sv
// Self-checking bench for pit_table: scenario tasks plus a payload scoreboard.
module tb_pit_table;

  localparam int unsigned Entries      = 4;
  localparam int unsigned Lifetime     = 1024;
  localparam int unsigned PayloadBytes = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        interest_valid;
  logic [63:0] interest_prefix;
  logic [5:0]  interest_len;
  logic        interest_ready;
  logic        interest_drop;
  logic [63:0] pit_in_prefix;
  logic [5:0]  pit_in_len;
  logic        fib_out_bit;
  logic [63:0] pit_out_prefix;
  logic [5:0]  pit_out_len;
  logic        prefix_ready;
  logic        start_send;
  logic        rejected;
  logic [7:0]  out_data;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_last;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rx_cnt = 0;

  localparam logic [63:0] PfxA = 64'h0000FFFF0000FFFF;
  localparam logic [63:0] PfxB = 64'hABCDE00000000000;
  localparam logic [63:0] PfxE = 64'h5555000000000000;

  pit_table #(
    .ENTRIES      (Entries),
    .LIFETIME     (Lifetime),
    .PAYLOAD_BYTES(PayloadBytes)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .interest_valid_i   (interest_valid),
    .interest_prefix_i  (interest_prefix),
    .interest_len_i     (interest_len),
    .interest_ready_o   (interest_ready),
    .interest_drop_o    (interest_drop),
    .pit_in_prefix_o    (pit_in_prefix),
    .pit_in_len_o       (pit_in_len),
    .fib_out_bit_o      (fib_out_bit),
    .pit_out_prefix_i   (pit_out_prefix),
    .pit_out_len_i      (pit_out_len),
    .prefix_ready_i     (prefix_ready),
    .start_send_to_pit_o(start_send),
    .rejected_o         (rejected),
    .out_data_i         (out_data),
    .data_out_o         (data_out),
    .data_out_valid_o   (data_out_valid),
    .data_out_last_o    (data_out_last),
    .occupancy_o        (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; mid-cycle, retire any payload byte against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (data_out_valid === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got data_out=%h last=%b, required no output",
                 data_out, data_out_last);
      end else begin
        e = sb_q.pop_front();
        rx_cnt++;
        if (data_out !== e.data || data_out_last !== e.last) begin
          bad++;
          $display("FAIL sb_byte: got %h last=%b, required %h last=%b",
                   data_out, data_out_last, e.data, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted interest then return to an idle cycle (no checks).
  task automatic insert(input logic [63:0] p, input logic [5:0] l);
    interest_valid  = 1'b1;
    interest_prefix = p;
    interest_len    = l;
    tick();
    interest_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (interest_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b, required 0", interest_ready);
    end
    total++;
    if ({interest_drop, fib_out_bit, start_send, rejected, data_out_valid, data_out_last}
        !== 6'b0) begin
      bad++; $display("FAIL reset_pulses: got %b, required 000000",
                      {interest_drop, fib_out_bit, start_send, rejected,
                       data_out_valid, data_out_last});
    end
    total++;
    if (pit_in_prefix !== 64'd0 || pit_in_len !== 6'd0 || data_out !== 8'd0) begin
      bad++; $display("FAIL reset_data: got pit_in=%h/%0d data_out=%h, required 0",
                      pit_in_prefix, pit_in_len, data_out);
    end
    total++;
    if (occupancy !== 3'd0) begin
      bad++; $display("FAIL reset_occ: got %0d, required 0", occupancy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (interest_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: got %b, required 1", interest_ready);
    end
  endtask

  task automatic test_forward();
    interest_valid  = 1'b1;
    interest_prefix = PfxA;
    interest_len    = 6'd48;
    tick();
    interest_valid = 1'b0;
    total++;
    if (fib_out_bit !== 1'b0 || occupancy !== 3'd1) begin
      bad++; $display("FAIL fwd_cycle1: got fib=%b occ=%0d, required fib=0 occ=1",
                      fib_out_bit, occupancy);
    end
    tick();
    total++;
    if (fib_out_bit !== 1'b1 || pit_in_prefix !== PfxA || pit_in_len !== 6'd48) begin
      bad++; $display("FAIL fwd_strobe: got fib=%b pit_in=%h/%0d, required 1 %h/48",
                      fib_out_bit, pit_in_prefix, pit_in_len, PfxA);
    end
    tick();
    total++;
    if (fib_out_bit !== 1'b0 || pit_in_prefix !== PfxA) begin
      bad++; $display("FAIL fwd_after: got fib=%b pit_in=%h, required 0 %h",
                      fib_out_bit, pit_in_prefix, PfxA);
    end
  endtask

  task automatic test_refresh();
    interest_valid  = 1'b1;
    interest_prefix = {PfxA[63:16], 16'h1234};
    interest_len    = 6'd48;
    tick();
    interest_valid = 1'b0;
    total++;
    if (occupancy !== 3'd1 || interest_drop !== 1'b0) begin
      bad++; $display("FAIL refresh_occ: got occ=%0d drop=%b, required 1 0",
                      occupancy, interest_drop);
    end
    tick();
    total++;
    if (fib_out_bit !== 1'b0) begin
      bad++; $display("FAIL refresh_nofwd: got fib=%b, required 0", fib_out_bit);
    end
    repeat (Lifetime - 2) tick();
    total++;
    if (occupancy !== 3'd1) begin
      bad++; $display("FAIL refresh_alive: got occ=%0d, required 1", occupancy);
    end
    tick();
    total++;
    if (occupancy !== 3'd0) begin
      bad++; $display("FAIL refresh_expired: got occ=%0d, required 0", occupancy);
    end
  endtask

  task automatic test_satisfy();
    insert(PfxA, 6'd48);
    prefix_ready    = 1'b1;
    pit_out_prefix  = PfxA;
    pit_out_len     = 6'd48;
    interest_valid  = 1'b1;
    interest_prefix = 64'hDEAD000000000000;
    interest_len    = 6'd16;
    #1;
    total++;
    if (interest_ready !== 1'b0) begin
      bad++; $display("FAIL priority_ready: got %b, required 0", interest_ready);
    end
    tick();
    prefix_ready   = 1'b0;
    interest_valid = 1'b0;
    total++;
    if (start_send !== 1'b1 || rejected !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL satisfy_start: got start=%b rej=%b occ=%0d, required 1 0 0",
                      start_send, rejected, occupancy);
    end
    rx_cnt = 0;
    for (int k = 0; k < PayloadBytes; k++) begin
      tick();
      out_data = 8'(k + 1);
      sb_q.push_back('{data: 8'(k + 1), last: (k == PayloadBytes - 1)});
      if (k == 0) begin
        total++;
        if (start_send !== 1'b0) begin
          bad++; $display("FAIL start_once: got %b, required 0", start_send);
        end
      end
    end
    tick();
    tick();
    total++;
    if (rx_cnt != PayloadBytes || sb_q.size() != 0) begin
      bad++; $display("FAIL satisfy_count: got %0d bytes, %0d pending, required 8 0",
                      rx_cnt, sb_q.size());
    end
    total++;
    if (fib_out_bit !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL satisfy_noagg: got fib=%b occ=%0d, required 0 0",
                      fib_out_bit, occupancy);
    end
  endtask

  task automatic test_reject();
    prefix_ready   = 1'b1;
    pit_out_prefix = PfxA;
    pit_out_len    = 6'd32;
    tick();
    prefix_ready = 1'b0;
    total++;
    if (rejected !== 1'b1 || start_send !== 1'b0) begin
      bad++; $display("FAIL reject_pulse: got rej=%b start=%b, required 1 0",
                      rejected, start_send);
    end
    tick();
    total++;
    if (rejected !== 1'b0) begin
      bad++; $display("FAIL reject_once: got %b, required 0", rejected);
    end
  endtask

  task automatic test_reject_during_rx();
    insert(PfxB, 6'd20);
    prefix_ready   = 1'b1;
    pit_out_prefix = PfxB;
    pit_out_len    = 6'd20;
    tick();
    prefix_ready = 1'b0;
    total++;
    if (start_send !== 1'b1) begin
      bad++; $display("FAIL rx_start: got %b, required 1", start_send);
    end
    rx_cnt = 0;
    for (int k = 0; k < PayloadBytes; k++) begin
      tick();
      prefix_ready = (k == 2);
      if (k == 3) begin
        total++;
        if (rejected !== 1'b1 || start_send !== 1'b0) begin
          bad++; $display("FAIL rx_reject: got rej=%b start=%b, required 1 0",
                          rejected, start_send);
        end
      end
      out_data = 8'hA0 + 8'(k);
      sb_q.push_back('{data: 8'hA0 + 8'(k), last: (k == PayloadBytes - 1)});
    end
    prefix_ready = 1'b0;
    tick();
    tick();
    total++;
    if (rx_cnt != PayloadBytes || sb_q.size() != 0) begin
      bad++; $display("FAIL rx_intact: got %0d bytes, %0d pending, required 8 0",
                      rx_cnt, sb_q.size());
    end
  endtask

  task automatic test_full_expiry();
    for (int i = 0; i < Entries; i++) begin
      insert({8'(8'h10 + 8'(i)), 56'd0}, 6'd32);
    end
    total++;
    if (occupancy !== 3'd4) begin
      bad++; $display("FAIL full_occ: got %0d, required 4", occupancy);
    end
    interest_valid  = 1'b1;
    interest_prefix = PfxE;
    interest_len    = 6'd16;
    tick();
    interest_valid = 1'b0;
    total++;
    if (interest_drop !== 1'b1 || fib_out_bit !== 1'b0) begin
      bad++; $display("FAIL full_drop: got drop=%b fib=%b, required 1 0",
                      interest_drop, fib_out_bit);
    end
    tick();
    total++;
    if (interest_drop !== 1'b0 || occupancy !== 3'd4) begin
      bad++; $display("FAIL full_after: got drop=%b occ=%0d, required 0 4",
                      interest_drop, occupancy);
    end
    repeat (Lifetime) tick();
    total++;
    if (occupancy !== 3'd0) begin
      bad++; $display("FAIL expiry_occ: got %0d, required 0", occupancy);
    end
    interest_valid = 1'b1;
    tick();
    interest_valid = 1'b0;
    tick();
    total++;
    if (fib_out_bit !== 1'b1 || pit_in_prefix !== PfxE || occupancy !== 3'd1) begin
      bad++; $display("FAIL expiry_fwd: got fib=%b pit_in=%h occ=%0d, required 1 %h 1",
                      fib_out_bit, pit_in_prefix, occupancy, PfxE);
    end
    tick();
  endtask

  task automatic test_reset_mid_payload();
    prefix_ready   = 1'b1;
    pit_out_prefix = PfxE;
    pit_out_len    = 6'd16;
    tick();
    prefix_ready = 1'b0;
    total++;
    if (start_send !== 1'b1) begin
      bad++; $display("FAIL mid_start: got %b, required 1", start_send);
    end
    rx_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      out_data = 8'h31 + 8'(k);
      sb_q.push_back('{data: 8'h31 + 8'(k), last: 1'b0});
    end
    rst = 1'b1;
    tick();
    sb_q.delete();
    total++;
    if (data_out_valid !== 1'b0 || data_out_last !== 1'b0 || data_out !== 8'd0 ||
        occupancy !== 3'd0) begin
      bad++; $display("FAIL mid_reset: got v=%b last=%b d=%h occ=%0d, required 0 0 00 0",
                      data_out_valid, data_out_last, data_out, occupancy);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_data = 8'h40 + 8'(k);
      tick();
    end
    total++;
    if (rx_cnt != 2) begin
      bad++; $display("FAIL mid_partial: got %0d bytes, required 2", rx_cnt);
    end
    prefix_ready = 1'b1;
    tick();
    prefix_ready = 1'b0;
    total++;
    if (rejected !== 1'b1 || start_send !== 1'b0) begin
      bad++; $display("FAIL mid_empty: got rej=%b start=%b, required 1 0",
                      rejected, start_send);
    end
    tick();
  endtask

  initial begin
    rst             = 1'b1;
    interest_valid  = 1'b0;
    interest_prefix = '0;
    interest_len    = '0;
    pit_out_prefix  = '0;
    pit_out_len     = '0;
    prefix_ready    = 1'b0;
    out_data        = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_refresh();
    test_satisfy();
    test_reject();
    test_reject_during_rx();
    test_full_expiry();
    test_reset_mid_payload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pit_table.md
Name: pit_table

Overview:
- Pending Interest Table stage sitting directly upstream of the fib block.
- Records incoming interests and forwards new ones to fib via the pit_in_* / fib_out_bit lines.
- Aggregates duplicate interests.
- Matches returning data announcements (prefix_ready, pit_out_*) against pending entries, then either pulls the payload bytes on out_data or answers with rejected.
- Entries age out after a fixed lifetime.

Parameters:
ENTRIES, 4, number of pending-interest slots (2..16)
LIFETIME, 1024, cycles an entry survives without refresh
PAYLOAD_BYTES, 8, data bytes streamed by fib per satisfied interest (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
interest_valid  in  1  upstream interest present
interest_prefix  in  64  interest name, MSB-aligned
interest_len  in  6  significant prefix bits
interest_ready  out  1  PIT can accept interest this cycle
interest_drop  out  1  one-cycle pulse: interest dropped, table full
pit_in_prefix  out  64  prefix forwarded to fib
pit_in_len  out  6  length forwarded to fib
fib_out_bit  out  1  one-cycle strobe: pit_in_* valid
pit_out_prefix  in  64  data prefix announced by fib
pit_out_len  in  6  data prefix length
prefix_ready  in  1  one-cycle strobe: pit_out_* valid
start_send_to_pit  out  1  one-cycle pulse: accept payload, fib begins streaming
rejected  out  1  one-cycle pulse: announced data has no pending entry
out_data  in  8  payload byte from fib
data_out  out  8  payload byte to downstream
data_out_valid  out  1  data_out valid
data_out_last  out  1  final payload byte
occupancy  out  $clog2(ENTRIES+1)  valid entry count

Behaviour:
- Reset: all outputs 0, all entries invalid, state IDLE. interest_ready is 0 while rst is high.
- Match rule: entry matches a (prefix, len) pair when all of the following hold:
  - entry valid;
  - entry len equals len;
  - top len bits [63 -: len] are equal; lower bits are ignored.
  - len 0 matches any valid len-0 entry.
- States: IDLE, FWD, DATA_RX.
- Ready rule: interest_ready = (state==IDLE) && !prefix_ready. Data announcements take priority over interests.
- IDLE, interest accepted (valid&&ready), lookup in the same cycle:
  - hit: reset that entry's lifetime to LIFETIME; no forward; stay IDLE.
  - miss with free slot: write into the lowest-index free slot with lifetime LIFETIME; register prefix/len onto pit_in_*; go FWD.
  - miss with table full: interest_drop pulses the next cycle; stay IDLE.
- FWD: fib_out_bit=1 for exactly one cycle, pit_in_* held stable. Next state IDLE. pit_in_* retain their value afterwards.
- IDLE, prefix_ready:
  - hit: invalidate the entry; start_send_to_pit pulses the next cycle; enter DATA_RX.
  - miss: rejected pulses the next cycle; stay IDLE.
- prefix_ready in FWD or DATA_RX: no lookup, rejected pulses the next cycle; the state sequence is unaffected.
- DATA_RX: fib drives payload byte k on out_data k+1 cycles after the start_send_to_pit cycle, for k = 0..PAYLOAD_BYTES-1.
  - PIT registers each byte: data_out_valid=1 and data_out=byte one cycle later.
  - data_out_last accompanies byte PAYLOAD_BYTES-1.
  - Then return to IDLE. No downstream backpressure.
- Lifetime: each valid entry's counter decrements every cycle; on reaching 1 the entry is invalidated at that clock edge.
  - Same-cycle expiry and hit (refresh or satisfy) on the same entry: the hit wins.
  - A slot freed by expiry becomes allocatable the following cycle.
- Duplicate insertion never occurs: at most one entry per (prefix, len).
- occupancy: registered, updates the cycle after an insert, satisfy or expiry.
- rst asserted mid-operation (any state, including mid-payload): next edge returns to reset values; partial payload is discarded with no data_out_last.

Test Plan:
- Forward new interest: interest 64'h0000FFFF0000FFFF, len 48 -> fib_out_bit pulses 2 cycles after acceptance, pit_in_prefix=64'h0000FFFF0000FFFF, pit_in_len=48, occupancy=1.
- Aggregation/refresh: same interest again, with lower 16 bits changed to 16'h1234 -> no fib_out_bit, occupancy stays 1, entry survives LIFETIME cycles from the second arrival.
- Satisfy: prefix_ready with pit_out_prefix=64'h0000FFFF0000FFFF, len 48 -> start_send_to_pit next cycle; bytes 8'h01..8'h08 on out_data -> data_out 8'h01..8'h08, data_out_last with 8'h08, occupancy=0.
- Reject: prefix_ready with len 32 on an empty table -> rejected pulse, no start_send_to_pit. prefix_ready during DATA_RX -> rejected, payload completes intact.
- Full/expiry: 4 distinct interests then a 5th -> interest_drop pulse, occupancy=4. After LIFETIME=1024 idle cycles -> occupancy=0, 5th interest now forwarded.
- Reset mid-payload: assert rst at byte 3 of 8 -> outputs zero next edge, no data_out_last, table empty.
